// File: rtl/rs_issue_queue.sv
// rs_issue_queue: single reservation station for one functional-unit group.
// Buffers dispatched uops until both source tags are ready, then offers the
// oldest ready entry to the FU.
//
// Ports:
//   clk, rst_n            core clock, async active-low reset
//   flush                 synchronous squash of every entry
//   disp_*                dispatch uop in (valid/ready handshake)
//   wb_valid, wb_preg     wakeup broadcast of a tag becoming ready
//   sel_*                 oldest ready uop out (valid/ready handshake)
//   count                 number of occupied entries
//
// rs_entry holds one slot: payload, tags, and per-source ready bits. It
// snoops the wakeup bus and is allocated/freed by the top level.

module rs_entry #(
    parameter int PREG_W = 6,
    parameter int OP_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              alloc,
    input  logic              issue,
    input  logic [OP_W-1:0]   d_op,
    input  logic [PREG_W-1:0] d_src1,
    input  logic [PREG_W-1:0] d_src2,
    input  logic [PREG_W-1:0] d_dst,
    input  logic              d_rdy1,
    input  logic              d_rdy2,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    output logic              valid,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [PREG_W-1:0] src1,
    output logic [PREG_W-1:0] src2,
    output logic [PREG_W-1:0] dst
);
    logic rdy1, rdy2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            op    <= '0;
            src1  <= '0;
            src2  <= '0;
            dst   <= '0;
            rdy1  <= 1'b0;
            rdy2  <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (alloc) begin
            // Wakeup broadcast in the dispatch cycle is folded in here so the
            // tag is not missed.
            valid <= 1'b1;
            op    <= d_op;
            src1  <= d_src1;
            src2  <= d_src2;
            dst   <= d_dst;
            rdy1  <= d_rdy1 | (wb_valid && (wb_preg == d_src1));
            rdy2  <= d_rdy2 | (wb_valid && (wb_preg == d_src2));
        end else begin
            if (issue)
                valid <= 1'b0;
            if (valid && wb_valid && (wb_preg == src1))
                rdy1 <= 1'b1;
            if (valid && wb_valid && (wb_preg == src2))
                rdy2 <= 1'b1;
        end
    end

    assign ready = valid && rdy1 && rdy2;
endmodule

module rs_issue_queue #(
    parameter  int RS_ENTRIES = 8,
    parameter  int PREG_W     = 6,
    parameter  int OP_W       = 8,
    localparam int CNT_W      = $clog2(RS_ENTRIES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [PREG_W-1:0] disp_src1,
    input  logic [PREG_W-1:0] disp_src2,
    input  logic              disp_src1_rdy,
    input  logic              disp_src2_rdy,
    input  logic [PREG_W-1:0] disp_dst,
    input  logic              wb_valid,
    input  logic [PREG_W-1:0] wb_preg,
    output logic              sel_valid,
    input  logic              sel_ready,
    output logic [OP_W-1:0]   sel_op,
    output logic [PREG_W-1:0] sel_src1,
    output logic [PREG_W-1:0] sel_src2,
    output logic [PREG_W-1:0] sel_dst,
    output logic [CNT_W-1:0]  count
);
    logic [RS_ENTRIES-1:0]             e_valid, e_ready;
    logic [RS_ENTRIES-1:0]             free_oh, alloc_oh, sel_oh, issue_oh;
    logic [RS_ENTRIES-1:0][OP_W-1:0]   e_op;
    logic [RS_ENTRIES-1:0][PREG_W-1:0] e_src1, e_src2, e_dst;
    // older[i][j] set: entry i was dispatched before entry j.
    logic [RS_ENTRIES-1:0][RS_ENTRIES-1:0] older;
    logic accept, issue;

    assign disp_ready = (count < CNT_W'(RS_ENTRIES));
    assign sel_valid  = |e_ready;
    assign accept     = disp_valid && disp_ready && !flush;
    assign issue      = sel_valid && sel_ready && !flush;

    // Lowest-index free slot; count < RS_ENTRIES guarantees one exists.
    assign free_oh  = ~e_valid & (e_valid + RS_ENTRIES'(1));
    assign alloc_oh = accept ? free_oh : '0;
    assign issue_oh = issue ? sel_oh : '0;

    rs_entry #(.PREG_W(PREG_W), .OP_W(OP_W)) u_entry [RS_ENTRIES-1:0] (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .alloc    (alloc_oh),
        .issue    (issue_oh),
        .d_op     (disp_op),
        .d_src1   (disp_src1),
        .d_src2   (disp_src2),
        .d_dst    (disp_dst),
        .d_rdy1   (disp_src1_rdy),
        .d_rdy2   (disp_src2_rdy),
        .wb_valid (wb_valid),
        .wb_preg  (wb_preg),
        .valid    (e_valid),
        .ready    (e_ready),
        .op       (e_op),
        .src1     (e_src1),
        .src2     (e_src2),
        .dst      (e_dst)
    );

    // An entry wins when no other ready entry is older than it.
    for (genvar i = 0; i < RS_ENTRIES; i++) begin : g_sel
        logic [RS_ENTRIES-1:0] older_than_i;
        for (genvar j = 0; j < RS_ENTRIES; j++) begin : g_col
            assign older_than_i[j] = older[j][i];
        end
        assign sel_oh[i] = e_ready[i] && !(|(older_than_i & e_ready));
    end

    always_comb begin
        sel_op   = '0;
        sel_src1 = '0;
        sel_src2 = '0;
        sel_dst  = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                sel_op   = e_op[i];
                sel_src1 = e_src1[i];
                sel_src2 = e_src2[i];
                sel_dst  = e_dst[i];
            end
        end
    end

    // A newly allocated slot becomes younger than everything else. Stale
    // bits of free slots are harmless: only ready (hence valid) entries
    // participate in select, and reallocation rewrites the row and column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older <= '0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (alloc_oh[i])
                        older[i][j] <= 1'b0;
                    else if (alloc_oh[j])
                        older[i][j] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (flush)
            count <= '0;
        else begin
            case ({accept, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_issue_queue.sv
// Bench for rs_issue_queue: directed vector table, hand-written multi-cycle
// sequences (full, flush, reset) and random traffic, all compared against a
// queue-based age-ordered reference model.
module tb_rs_issue_queue;
    localparam int RS_ENTRIES = 8;
    localparam int PREG_W     = 6;
    localparam int OP_W       = 8;
    localparam int CNT_W      = $clog2(RS_ENTRIES + 1);

    logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic              disp_valid = 1'b0, disp_ready;
    logic [OP_W-1:0]   disp_op = '0;
    logic [PREG_W-1:0] disp_src1 = '0, disp_src2 = '0, disp_dst = '0;
    logic              disp_src1_rdy = 1'b0, disp_src2_rdy = 1'b0;
    logic              wb_valid = 1'b0;
    logic [PREG_W-1:0] wb_preg = '0;
    logic              sel_valid, sel_ready = 1'b0;
    logic [OP_W-1:0]   sel_op;
    logic [PREG_W-1:0] sel_src1, sel_src2, sel_dst;
    logic [CNT_W-1:0]  count;

    rs_issue_queue #(.RS_ENTRIES(RS_ENTRIES), .PREG_W(PREG_W), .OP_W(OP_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_dst(disp_dst), .wb_valid(wb_valid), .wb_preg(wb_preg),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_op(sel_op),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .sel_dst(sel_dst),
        .count(count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    // Reference model: uops kept oldest-first in a queue.
    typedef struct {
        logic [OP_W-1:0]   op;
        logic [PREG_W-1:0] s1, s2, dst;
        bit                r1, r2;
    } m_uop_t;
    m_uop_t mq[$];

    typedef struct {
        bit                fl, dv;
        logic [OP_W-1:0]   op;
        logic [PREG_W-1:0] s1;
        bit                r1;
        logic [PREG_W-1:0] s2;
        bit                r2;
        logic [PREG_W-1:0] dst;
        bit                wbv;
        logic [PREG_W-1:0] wbp;
        bit                sr;
        bit                e_sv;
        logic [OP_W-1:0]   e_op;
        logic [PREG_W-1:0] e_dst;
        int                e_cnt;
        bit                e_dr;
    } vec_t;
    vec_t vt[14];

    function automatic vec_t mk(bit dv, int op, int s1, bit r1, int s2, bit r2, int dst,
                                bit wbv, int wbp, bit sr,
                                bit esv, int eop, int edst, int ecnt, bit edr);
        vec_t v;
        v.fl = 1'b0; v.dv = dv; v.op = OP_W'(op);
        v.s1 = PREG_W'(s1); v.r1 = r1; v.s2 = PREG_W'(s2); v.r2 = r2;
        v.dst = PREG_W'(dst); v.wbv = wbv; v.wbp = PREG_W'(wbp); v.sr = sr;
        v.e_sv = esv; v.e_op = OP_W'(eop); v.e_dst = PREG_W'(edst);
        v.e_cnt = ecnt; v.e_dr = edr;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_sel();
        foreach (mq[i])
            if (mq[i].r1 && mq[i].r2) return i;
        return -1;
    endfunction

    task automatic model_step();
        int     idx;
        bit     acc;
        m_uop_t u;
        if (flush) begin
            mq.delete();
            return;
        end
        idx = model_sel();
        acc = disp_valid && (mq.size() < RS_ENTRIES);
        if (idx >= 0 && sel_ready) mq.delete(idx);
        if (wb_valid) begin
            foreach (mq[i]) begin
                u = mq[i];
                if (u.s1 == wb_preg) u.r1 = 1'b1;
                if (u.s2 == wb_preg) u.r2 = 1'b1;
                mq[i] = u;
            end
        end
        if (acc) begin
            u.op = disp_op; u.s1 = disp_src1; u.s2 = disp_src2; u.dst = disp_dst;
            u.r1 = disp_src1_rdy || (wb_valid && disp_src1 == wb_preg);
            u.r2 = disp_src2_rdy || (wb_valid && disp_src2 == wb_preg);
            mq.push_back(u);
        end
    endtask

    task automatic check_outputs(string tag);
        int                idx = model_sel();
        logic [OP_W-1:0]   eop = '0;
        logic [PREG_W-1:0] es1 = '0, es2 = '0, edst = '0;
        if (idx >= 0) begin
            eop = mq[idx].op; es1 = mq[idx].s1; es2 = mq[idx].s2; edst = mq[idx].dst;
        end
        check({tag, "_sel_valid"}, sel_valid, idx >= 0);
        check({tag, "_sel_op"}, sel_op, eop);
        check({tag, "_sel_src1"}, sel_src1, es1);
        check({tag, "_sel_src2"}, sel_src2, es2);
        check({tag, "_sel_dst"}, sel_dst, edst);
        check({tag, "_count"}, count, mq.size());
        check({tag, "_disp_ready"}, disp_ready, mq.size() < RS_ENTRIES);
    endtask

    // Inputs are driven at the negedge; the model advances with the edge and
    // outputs are compared at the following negedge.
    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic set_disp(int op, int s1, bit r1, int s2, bit r2, int dst);
        disp_valid = 1'b1; disp_op = OP_W'(op);
        disp_src1 = PREG_W'(s1); disp_src1_rdy = r1;
        disp_src2 = PREG_W'(s2); disp_src2_rdy = r2;
        disp_dst = PREG_W'(dst);
    endtask

    task automatic set_idle(bit sr);
        flush = 1'b0; disp_valid = 1'b0; wb_valid = 1'b0; sel_ready = sr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: ready dispatch, wakeup + dispatch bypass, age order.
        vt[0]  = mk(1, 'h11, 3, 1, 4, 1,  9, 0, 0, 1,  1, 'h11,  9, 1, 1);
        vt[1]  = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  0, 0,     0, 0, 1);
        vt[2]  = mk(1, 'h21, 5, 0, 6, 1, 10, 0, 0, 1,  0, 0,     0, 1, 1);
        vt[3]  = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  0, 0,     0, 1, 1);
        vt[4]  = mk(1, 'h22, 5, 0, 8, 1, 11, 1, 5, 1,  1, 'h21, 10, 2, 1);
        vt[5]  = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  1, 'h22, 11, 1, 1);
        vt[6]  = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  0, 0,     0, 0, 1);
        vt[7]  = mk(1, 'h31, 7, 0, 1, 1, 12, 0, 0, 1,  0, 0,     0, 1, 1);
        vt[8]  = mk(1, 'h32, 7, 0, 1, 1, 13, 0, 0, 1,  0, 0,     0, 2, 1);
        vt[9]  = mk(1, 'h33, 7, 0, 1, 1, 14, 0, 0, 1,  0, 0,     0, 3, 1);
        vt[10] = mk(0, 0,    0, 0, 0, 0,  0, 1, 7, 1,  1, 'h31, 12, 3, 1);
        vt[11] = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  1, 'h32, 13, 2, 1);
        vt[12] = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  1, 'h33, 14, 1, 1);
        vt[13] = mk(0, 0,    0, 0, 0, 0,  0, 0, 0, 1,  0, 0,     0, 0, 1);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_sel_valid", sel_valid, 0);
        check("reset_count", count, 0);
        check("reset_disp_ready", disp_ready, 1);
        check("reset_sel_op", sel_op, 0);
        check("reset_sel_dst", sel_dst, 0);
        rst_n = 1'b1;

        foreach (vt[k]) begin
            flush = vt[k].fl; disp_valid = vt[k].dv; disp_op = vt[k].op;
            disp_src1 = vt[k].s1; disp_src1_rdy = vt[k].r1;
            disp_src2 = vt[k].s2; disp_src2_rdy = vt[k].r2;
            disp_dst = vt[k].dst; wb_valid = vt[k].wbv; wb_preg = vt[k].wbp;
            sel_ready = vt[k].sr;
            tick($sformatf("vec%0d", k));
            check($sformatf("vec%0d_sv", k), sel_valid, vt[k].e_sv);
            check($sformatf("vec%0d_op", k), sel_op, vt[k].e_op);
            check($sformatf("vec%0d_dst", k), sel_dst, vt[k].e_dst);
            check($sformatf("vec%0d_cnt", k), count, vt[k].e_cnt);
            check($sformatf("vec%0d_dr", k), disp_ready, vt[k].e_dr);
        end

        // Full / back-pressure.
        set_idle(1'b0);
        for (int i = 0; i < RS_ENTRIES; i++) begin
            set_disp('h40 + i, 1, 1, 2, 1, i);
            tick("fill");
        end
        check("full_count", count, 8);
        check("full_disp_ready", disp_ready, 0);
        check("full_sel_op", sel_op, 'h40);
        set_disp('h50, 1, 1, 2, 1, 20);
        tick("ninth");
        check("ninth_count", count, 8);
        // Freeing a slot the same cycle must not admit the offer.
        sel_ready = 1'b1;
        tick("full_issue");
        check("full_issue_count", count, 7);
        check("full_issue_dr", disp_ready, 1);
        check("full_issue_op", sel_op, 'h41);
        set_disp('h51, 1, 1, 2, 1, 21);
        tick("disp_and_sel");
        check("disp_and_sel_count", count, 7);
        check("disp_and_sel_op", sel_op, 'h42);
        set_idle(1'b1);
        repeat (7) tick("drain");
        check("drain_count", count, 0);

        // Flush with coincident dispatch and select.
        set_idle(1'b0);
        for (int i = 0; i < 5; i++) begin
            set_disp('h70 + i, 3, 1, 4, 1, i);
            tick("pre_flush");
        end
        check("pre_flush_count", count, 5);
        flush = 1'b1; sel_ready = 1'b1;
        set_disp('h60, 1, 1, 2, 1, 30);
        tick("flush");
        check("flush_count", count, 0);
        check("flush_sel_valid", sel_valid, 0);
        set_idle(1'b1);
        tick("post_flush");
        check("post_flush_sel_valid", sel_valid, 0);

        // Asynchronous reset mid-traffic.
        set_idle(1'b0);
        for (int i = 0; i < 3; i++) begin
            set_disp('h80 + i, 1, 1, 2, 1, i);
            tick("pre_rst");
        end
        rst_n = 1'b0;
        #1;
        check("rst_async_count", count, 0);
        check("rst_async_sel_valid", sel_valid, 0);
        check("rst_async_disp_ready", disp_ready, 1);
        mq.delete();
        @(posedge clk);
        @(negedge clk);
        set_idle(1'b1);
        rst_n = 1'b1;
        tick("post_rst");
        tick("post_rst");
        check("post_rst_sel_valid", sel_valid, 0);
        check("post_rst_count", count, 0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            flush         = ($urandom_range(0, 59) == 0);
            disp_valid    = ($urandom_range(0, 9) < 7);
            disp_op       = OP_W'($urandom);
            disp_src1     = PREG_W'($urandom_range(0, 7));
            disp_src2     = PREG_W'($urandom_range(0, 7));
            disp_src1_rdy = ($urandom_range(0, 1) == 1);
            disp_src2_rdy = ($urandom_range(0, 1) == 1);
            disp_dst      = PREG_W'($urandom);
            wb_valid      = ($urandom_range(0, 1) == 1);
            wb_preg       = PREG_W'($urandom_range(0, 7));
            sel_ready     = ((c / 300) % 2 == 0) ? ($urandom_range(0, 9) < 3)
                                                 : ($urandom_range(0, 9) < 8);
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
